alu_seq_unit: RTL and testbench
===============================

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits (power of two, >= 8).
REQ-002 Parameter SHIFT_STEP, default 1, maximum shift distance per cycle in iterative mode (1..XLEN-1).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  unit can accept a request.
REQ-007 alu_op  input  2  class: 00 add, 01 sub, 10 decode funct fields, 11 add.
REQ-008 funct3  input  3  instruction funct3.
REQ-009 funct7  input  7  instruction funct7.
REQ-010 op  input  7  instruction opcode.
REQ-011 src_a  input  XLEN  operand A.
REQ-012 src_b  input  XLEN  operand B or immediate.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 result  output  XLEN  registered result.
REQ-016 zero  output  1  registered flag, result == 0.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 States IDLE, SHIFT, DONE; in_ready SHALL be 1 only in IDLE.
REQ-019 Accept = in_valid & in_ready; operands, decoded op and shift amount SHALL be captured on accept; inputs ignored otherwise.
REQ-020 Decode for alu_op=10 by funct3: 000 sub if {op[5],funct7[5]}==11 else add; 001 sll; 010 slt signed; 011 sltu; 100 xor; 101 sra if funct7[5] else srl; 110 or; 111 and.
REQ-021 Add/sub SHALL wrap modulo 2^XLEN; slt/sltu SHALL yield zero-extended 0 or 1.
REQ-022 Shift amount SHALL be src_b[log2(XLEN)-1:0]; upper bits ignored; sra SHALL fill with src_a[XLEN-1].
REQ-023 Non-shift ops: IDLE -> DONE on accept; out_valid high the next cycle (latency 1).
REQ-024 Shift with amount 0: IDLE -> DONE, result = src_a, latency 1.
REQ-025 Shift with amount n>0 (iterative mode): IDLE -> SHIFT; each SHIFT cycle shifts by min(SHIFT_STEP, remaining); SHIFT -> DONE when remaining reaches 0; out_valid latency = 1 + ceil(n/SHIFT_STEP).
REQ-026 In DONE, out_valid=1 and result/zero SHALL stay stable until out_ready=1; DONE -> IDLE on out_valid & out_ready.
REQ-027 No back-to-back accept in the transfer cycle: the next request is accepted no earlier than the cycle after returning to IDLE.
REQ-028 out_ready while not in DONE SHALL have no effect.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE, out_valid=0, result=0, zero=0, busy=0, remaining count=0.
REQ-030 Reset mid-SHIFT or in DONE SHALL discard the operation with no result delivered.
REQ-031 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-032 Macro ALU_BARREL_SHIFT_EN defined: all shifts SHALL complete in one cycle (IDLE -> DONE, latency 1), SHIFT state never entered, SHIFT_STEP unused.
REQ-033 Macro ALU_BARREL_SHIFT_EN undefined: shifts SHALL follow REQ-025; results identical in both modes.

Verification
REQ-034 Reset, then alu_op=00, A=0xFFFFFFFF, B=1 -> out_valid after 1 cycle, result=0, zero=1.
REQ-035 alu_op=10, funct3=000, op=0110011, funct7=0100000, A=5, B=7 -> result=0xFFFFFFFE, zero=0; same with op=0010011 -> result=12.
REQ-036 funct3=101, funct7=0100000, A=0x80000000, B=0x24 (amount 4), SHIFT_STEP=1, iterative -> result=0xF8000000 after 5 cycles, busy high throughout; barrel build -> 1 cycle.
REQ-037 funct3=010 A=0xFFFFFFFF B=1 -> result=1; funct3=011 same operands -> result=0.
REQ-038 Hold out_ready=0 for 3 cycles in DONE -> result stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-039 rst_n=0 during SHIFT of an amount-31 sll -> next cycle IDLE, out_valid=0, result=0; new request completes normally.

Source files
------------

// File: rtl/alu_seq_unit_if.sv
// -----------------------------------------------------------------------------
// alu_seq_unit_if
// Purpose : Request/response bundle for alu_seq_unit. Carries the operation
//           request (decode fields plus operands), the result handshake and
//           the status flags.
// Signals : in_valid/in_ready  - request handshake (requester -> unit)
//           alu_op             - 2-bit operation class
//           funct3/funct7/op   - instruction fields used when alu_op = 2'b10
//           src_a/src_b        - operands (src_b may carry an immediate)
//           out_valid/out_ready- result handshake (unit -> consumer)
//           result/zero        - registered result and result==0 flag
//           busy               - unit is not idle
// Modports: master - requester/consumer side
//           slave  - the ALU unit
// -----------------------------------------------------------------------------
interface alu_seq_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [6:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;

  modport master (
    output in_valid, alu_op, funct3, funct7, op, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, alu_op, funct3, funct7, op, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/alu_seq_unit.sv
// -----------------------------------------------------------------------------
// alu_seq_unit
// Purpose : Single-issue integer ALU with a valid/ready request port and a
//           valid/ready result port. Non-shift operations complete in one
//           cycle. Shifts either iterate SHIFT_STEP bits per cycle through the
//           SHIFT state, or finish in one cycle when the barrel shifter is
//           enabled.
// Ports   : clk    - clock, all state updates on the rising edge
//           rst_n  - synchronous active-low reset
//           bus    - alu_seq_unit_if.slave (request, result, status flags)
// Params  : XLEN       - datapath width (power of two, >= 8)
//           SHIFT_STEP - max shift distance per SHIFT cycle (1..XLEN-1)
// Macro   : ALU_BARREL_SHIFT_EN - when defined, every shift completes in a
//           single cycle and the SHIFT state is never entered.
// -----------------------------------------------------------------------------
module alu_seq_unit #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_unit_if.slave bus
);

  localparam int SHW = $clog2(XLEN);

`ifdef ALU_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  localparam logic [SHW-1:0] STEP = SHW'(SHIFT_STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
    OP_XOR, OP_SRL, OP_SRA, OP_OR,  OP_AND
  } op_t;

  state_t          r_state;
  op_t             r_op;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic [SHW-1:0]  r_remaining;

  state_t          w_state_next;
  op_t             w_op_next;
  logic [XLEN-1:0] w_result_next;
  logic            w_zero_next;
  logic [SHW-1:0]  w_remaining_next;

  op_t             w_dec_op;
  logic [SHW-1:0]  w_shamt;
  logic            w_is_shift;
  logic            w_go_iter;
  logic [XLEN-1:0] w_alu;
  logic [SHW-1:0]  w_step;
  logic [SHW-1:0]  w_rem_dec;
  logic [XLEN-1:0] w_shifted;

  // Only bit 5 of op and funct7 participates in decode.
  logic w_unused_bits;
  assign w_unused_bits = ^{bus.funct7[6], bus.funct7[4:0], bus.op[6], bus.op[4:0]};

  function automatic logic [XLEN-1:0] shift_by(input op_t o,
                                               input logic [XLEN-1:0] v,
                                               input logic [SHW-1:0] n);
    logic [XLEN-1:0] s;
    case (o)
      OP_SLL:  s = v << n;
      OP_SRA:  s = XLEN'($signed(v) >>> n);
      default: s = v >> n;
    endcase
    return s;
  endfunction

  function automatic logic [XLEN-1:0] alu_eval(input op_t o,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    case (o)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:  r = a ^ b;
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_SLL, OP_SRL, OP_SRA: r = shift_by(o, a, b[SHW-1:0]);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Operation decode from the request fields.
  always_comb begin
    w_dec_op = OP_ADD;
    case (bus.alu_op)
      2'b01: w_dec_op = OP_SUB;
      2'b10: begin
        case (bus.funct3)
          3'b000:  w_dec_op = ({bus.op[5], bus.funct7[5]} == 2'b11) ? OP_SUB : OP_ADD;
          3'b001:  w_dec_op = OP_SLL;
          3'b010:  w_dec_op = OP_SLT;
          3'b011:  w_dec_op = OP_SLTU;
          3'b100:  w_dec_op = OP_XOR;
          3'b101:  w_dec_op = bus.funct7[5] ? OP_SRA : OP_SRL;
          3'b110:  w_dec_op = OP_OR;
          default: w_dec_op = OP_AND;
        endcase
      end
      default: w_dec_op = OP_ADD;
    endcase
  end

  assign w_shamt    = bus.src_b[SHW-1:0];
  assign w_is_shift = (w_dec_op == OP_SLL) || (w_dec_op == OP_SRL) || (w_dec_op == OP_SRA);
  // Zero-distance shifts skip the SHIFT state: the result is just src_a.
  assign w_go_iter  = w_is_shift && (w_shamt != '0) && !BARREL;
  assign w_alu      = alu_eval(w_dec_op, bus.src_a, bus.src_b);

  // Iterative shift: r_result doubles as the accumulator while in SHIFT.
  assign w_step    = (r_remaining > STEP) ? STEP : r_remaining;
  assign w_rem_dec = r_remaining - w_step;
  assign w_shifted = shift_by(r_op, r_result, w_step);

  always_comb begin
    w_state_next     = r_state;
    w_op_next        = r_op;
    w_result_next    = r_result;
    w_zero_next      = r_zero;
    w_remaining_next = r_remaining;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_op_next = w_dec_op;
          if (w_go_iter) begin
            w_state_next     = S_SHIFT;
            w_result_next    = bus.src_a;
            w_remaining_next = w_shamt;
          end else begin
            w_state_next     = S_DONE;
            w_result_next    = w_alu;
            w_zero_next      = (w_alu == '0);
            w_remaining_next = '0;
          end
        end
      end
      S_SHIFT: begin
        w_result_next    = w_shifted;
        w_remaining_next = w_rem_dec;
        if (w_rem_dec == '0) begin
          w_state_next = S_DONE;
          w_zero_next  = (w_shifted == '0);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= OP_ADD;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_next;
      r_op        <= w_op_next;
      r_result    <= w_result_next;
      r_zero      <= w_zero_next;
      r_remaining <= w_remaining_next;
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;

endmodule

// File: tb/tb_alu_seq_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_unit
// Purpose : Directed self-checking bench for alu_seq_unit (XLEN=32,
//           SHIFT_STEP=1). Expected results and latencies are hand-computed.
//           Shift latencies follow ALU_BARREL_SHIFT_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_alu_seq_unit;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] F7_ALT = 7'b0100000;

`ifdef ALU_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_unit_if #(.XLEN(32)) bus();

  alu_seq_unit #(.XLEN(32), .SHIFT_STEP(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  function automatic int shlat(input int n);
    if (BARREL || n == 0) return 1;
    return 1 + n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly one cycle, then wait (bounded) for out_valid.
  task automatic issue(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [6:0] opc, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit busy_ok);
    bus.alu_op = aop; bus.funct3 = f3; bus.funct7 = f7; bus.op = opc;
    bus.src_a = a; bus.src_b = b; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      tick();
      lat++;
    end
    if (bus.busy !== 1'b1) busy_ok = 1'b0;
  endtask

  task automatic run(input string tag, input logic [1:0] aop, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [6:0] opc, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_res, input logic exp_zero,
                     input int exp_lat);
    int lat;
    bit bok;
    issue(aop, f3, f7, opc, a, b, lat, bok);
    check({tag, ".result"}, bus.result, exp_res);
    check({tag, ".zero"}, 32'(bus.zero), 32'(exp_zero));
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".busy"}, 32'(bok), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, ".in_ready_after"}, 32'(bus.in_ready), 32'd1);
    $display("vec %-14s A=%h B=%h -> result=%h zero=%0b latency=%0d", tag, a, b,
             bus.result, bus.zero, lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    bit bok;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.alu_op = 2'b00;
    bus.funct3 = 3'b000; bus.funct7 = 7'b0; bus.op = 7'b0;
    bus.src_a = '0; bus.src_b = '0;

    // Reset state.
    rst_n = 1'b0;
    tick();
    tick();
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.result", bus.result, 32'd0);
    check("rst.zero", 32'(bus.zero), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);

    // Arithmetic and decode.
    run("add_wrap", 2'b00, 3'b000, 7'd0, 7'd0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b1, 1);
    run("sub_r",    2'b10, 3'b000, F7_ALT, OP_R, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
    run("addi",     2'b10, 3'b000, F7_ALT, OP_I, 32'd5, 32'd7, 32'd12, 1'b0, 1);
    run("op01_sub", 2'b01, 3'b000, 7'd0, 7'd0, 32'd10, 32'd3, 32'd7, 1'b0, 1);
    run("sub_zero", 2'b01, 3'b000, 7'd0, 7'd0, 32'd9, 32'd9, 32'd0, 1'b1, 1);
    run("op11_add", 2'b11, 3'b111, 7'd0, 7'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1);
    run("slt",      2'b10, 3'b010, 7'd0, OP_R, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
    run("sltu",     2'b10, 3'b011, 7'd0, OP_R, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1);
    run("xor",      2'b10, 3'b100, 7'd0, OP_R, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0, 1);
    run("or",       2'b10, 3'b110, 7'd0, OP_R, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 1'b0, 1);
    run("and",      2'b10, 3'b111, 7'd0, OP_R, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1);

    // Shifts: amount taken from src_b[4:0] only.
    run("sra4",     2'b10, 3'b101, F7_ALT, OP_R, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, shlat(4));
    run("sra_pos",  2'b10, 3'b101, F7_ALT, OP_R, 32'h4000_0000, 32'h02, 32'h1000_0000, 1'b0, shlat(2));
    bus.out_ready = 1'b1;  // out_ready while shifting must not matter
    run("srl4",     2'b10, 3'b101, 7'd0, OP_R, 32'h8000_0000, 32'h04, 32'h0800_0000, 1'b0, shlat(4));
    run("sll_amt1", 2'b10, 3'b001, 7'd0, OP_R, 32'h0000_0001, 32'h21, 32'h0000_0002, 1'b0, shlat(1));
    run("sll_amt0", 2'b10, 3'b001, 7'd0, OP_R, 32'h0000_1234, 32'h20, 32'h0000_1234, 1'b0, shlat(0));
    run("sll31",    2'b10, 3'b001, 7'd0, OP_I, 32'h0000_0003, 32'h1F, 32'h8000_0000, 1'b0, shlat(31));

    // Result held in DONE while out_ready is low; requests ignored meanwhile.
    issue(2'b10, 3'b111, 7'd0, OP_R, 32'h0000_F0F0, 32'h0000_0FF0, lat, bok);
    check("hold.first", bus.result, 32'h0000_00F0);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.alu_op = 2'b00; bus.src_a = 32'hFFFF_0000; bus.src_b = 32'h1;
      tick();
      check("hold.result", bus.result, 32'h0000_00F0);
      check("hold.in_ready", 32'(bus.in_ready), 32'd0);
      check("hold.out_valid", 32'(bus.out_valid), 32'd1);
      $display("hold cycle %0d result=%h out_valid=%0b in_ready=%0b", i, bus.result,
               bus.out_valid, bus.in_ready);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("hold.release_busy", 32'(bus.busy), 32'd0);
    check("hold.release_valid", 32'(bus.out_valid), 32'd0);
    check("hold.release_in_ready", 32'(bus.in_ready), 32'd1);

    // No accept in the transfer cycle; accept the cycle after.
    issue(2'b00, 3'b000, 7'd0, 7'd0, 32'd1, 32'd1, lat, bok);
    check("b2b.first", bus.result, 32'd2);
    bus.alu_op = 2'b00; bus.src_a = 32'd4; bus.src_b = 32'd4;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    check("b2b.transfer_busy", 32'(bus.busy), 32'd0);
    check("b2b.transfer_valid", 32'(bus.out_valid), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    check("b2b.second_valid", 32'(bus.out_valid), 32'd1);
    check("b2b.second_result", bus.result, 32'd8);
    $display("b2b second result=%h out_valid=%0b", bus.result, bus.out_valid);
    tick();
    bus.out_ready = 1'b0;

    // Reset in the middle of a 31-bit shift discards it.
    bus.alu_op = 2'b10; bus.funct3 = 3'b001; bus.funct7 = 7'd0; bus.op = OP_R;
    bus.src_a = 32'd1; bus.src_b = 32'd31; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    check("midrst.busy_before", 32'(bus.busy), 32'd1);
    check("midrst.valid_before", 32'(bus.out_valid), BARREL ? 32'd1 : 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst.busy", 32'(bus.busy), 32'd0);
    check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst.result", bus.result, 32'd0);
    check("midrst.zero", 32'(bus.zero), 32'd0);
    check("midrst.in_ready", 32'(bus.in_ready), 32'd1);
    $display("midrst busy=%0b out_valid=%0b result=%h", bus.busy, bus.out_valid, bus.result);
    run("post_rst_add", 2'b00, 3'b000, 7'd0, 7'd0, 32'd1, 32'd2, 32'd3, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
